// File: rtl/interboard_link_if.sv
// Board-pin bundle between two interboard_link endpoints:
// bundled-data req/ack each way plus the remote reset line.
interface interboard_link_if;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       rx_ack;
  logic       rx_req;
  logic [7:0] rx_data;
  logic       tx_ack;
  logic       rst_remote_in;
  logic       rst_remote_out;

  modport master (
    output tx_req, tx_data, tx_ack, rst_remote_out,
    input  rx_ack, rx_req, rx_data, rst_remote_in
  );

  modport slave (
    input  tx_req, tx_data, tx_ack, rst_remote_out,
    output rx_ack, rx_req, rx_data, rst_remote_in
  );
endinterface

// File: rtl/interboard_link.sv
// Bingo board-to-board link endpoint: one 8-bit word per
// 4-phase req/ack transfer, TX and RX full duplex.
module interboard_link #(
  parameter int TIMEOUT     = 1000000,
  parameter int RST_STRETCH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       transmit,
  input  logic       ctrl_en,
  input  logic [2:0] ctrl_msg_type,
  input  logic [4:0] ctrl_number,
  output logic       inter_ready,
  output logic       tx_busy,
  output logic       tx_timeout,
  output logic       tx_overrun,
  output logic       interboard_en,
  output logic [2:0] interboard_msg_type,
  output logic [4:0] interboard_number,
  output logic       interboard_rst,
  interboard_link_if.master link
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int SW = $clog2(RST_STRETCH + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] S_LOAD = SW'(RST_STRETCH);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_WAIT_ACK,
    TX_WAIT_REL
  } tx_state_t;

  typedef enum logic {
    RX_IDLE,
    RX_WAIT_LOW
  } rx_state_t;

  logic ack_m, ack_s;
  logic req_m, req_s;
  logic rrst_m, rrst_s, rrst_q;

  tx_state_t     tx_st, tx_st_n;
  logic [TW-1:0] timer, timer_n;
  logic          req_n, ir_n, to_n, ovr_n;
  logic [7:0]    data_n;
  logic          go;

  rx_state_t  rx_st, rx_st_n;
  logic       ack_n, en_n;
  logic [2:0] msg_n;
  logic [4:0] num_n;

  logic [SW-1:0] stretch;

  assign go      = ctrl_en && transmit;
  assign tx_busy = (tx_st != TX_IDLE);
  assign link.rst_remote_out = (stretch != '0);

  // Two-flop synchronisers for the async pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_m  <= 1'b0;
      ack_s  <= 1'b0;
      req_m  <= 1'b0;
      req_s  <= 1'b0;
      rrst_m <= 1'b0;
      rrst_s <= 1'b0;
      rrst_q <= 1'b0;
      interboard_rst <= 1'b0;
    end else begin
      ack_m  <= link.rx_ack;
      ack_s  <= ack_m;
      req_m  <= link.rx_req;
      req_s  <= req_m;
      rrst_m <= link.rst_remote_in;
      rrst_s <= rrst_m;
      rrst_q <= rrst_s;
      interboard_rst <= rrst_s & ~rrst_q;
    end
  end

  // TX next state: accept, wait for ack with timeout, wait release.
  always_comb begin
    tx_st_n = tx_st;
    timer_n = timer;
    req_n   = link.tx_req;
    data_n  = link.tx_data;
    ir_n    = 1'b0;
    to_n    = 1'b0;
    ovr_n   = tx_overrun | (go && (tx_st != TX_IDLE));
    unique case (tx_st)
      TX_IDLE: begin
        if (go) begin
          data_n  = {ctrl_msg_type, ctrl_number};
          req_n   = 1'b1;
          timer_n = '0;
          tx_st_n = TX_WAIT_ACK;
        end
      end
      TX_WAIT_ACK: begin
        if (ack_s) begin
          req_n   = 1'b0;
          tx_st_n = TX_WAIT_REL;
        end else if (timer == T_LAST) begin
          req_n   = 1'b0;
          to_n    = 1'b1;
          tx_st_n = TX_IDLE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      TX_WAIT_REL: begin
        if (!ack_s) begin
          ir_n    = 1'b1;
          tx_st_n = TX_IDLE;
        end
      end
      default: tx_st_n = TX_IDLE;
    endcase
  end

  // TX state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st        <= TX_IDLE;
      timer        <= '0;
      link.tx_req  <= 1'b0;
      link.tx_data <= '0;
      inter_ready  <= 1'b0;
      tx_timeout   <= 1'b0;
      tx_overrun   <= 1'b0;
    end else begin
      tx_st        <= tx_st_n;
      timer        <= timer_n;
      link.tx_req  <= req_n;
      link.tx_data <= data_n;
      inter_ready  <= ir_n;
      tx_timeout   <= to_n;
      tx_overrun   <= ovr_n;
    end
  end

  // RX next state: capture on req, hold ack until req drops.
  always_comb begin
    rx_st_n = rx_st;
    ack_n   = link.tx_ack;
    en_n    = 1'b0;
    msg_n   = interboard_msg_type;
    num_n   = interboard_number;
    unique case (rx_st)
      RX_IDLE: begin
        if (req_s) begin
          msg_n   = link.rx_data[7:5];
          num_n   = link.rx_data[4:0];
          en_n    = 1'b1;
          ack_n   = 1'b1;
          rx_st_n = RX_WAIT_LOW;
        end
      end
      RX_WAIT_LOW: begin
        if (!req_s) begin
          ack_n   = 1'b0;
          rx_st_n = RX_IDLE;
        end
      end
      default: rx_st_n = RX_IDLE;
    endcase
  end

  // RX state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st               <= RX_IDLE;
      link.tx_ack         <= 1'b0;
      interboard_en       <= 1'b0;
      interboard_msg_type <= '0;
      interboard_number   <= '0;
    end else begin
      rx_st               <= rx_st_n;
      link.tx_ack         <= ack_n;
      interboard_en       <= en_n;
      interboard_msg_type <= msg_n;
      interboard_number   <= num_n;
    end
  end

  // Hold the peer in reset a while after local reset lifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      stretch <= S_LOAD;
    end else if (stretch != '0) begin
      stretch <= stretch - 1'b1;
    end
  end
endmodule

// File: tb/tb_interboard_link.sv
// Directed self-checking bench for interboard_link.
// Inputs change 1ns after posedge; outputs sampled there.
module tb_interboard_link;
  logic       clk;
  logic       rst;
  logic       transmit;
  logic       ctrl_en;
  logic [2:0] ctrl_msg_type;
  logic [4:0] ctrl_number;
  logic       inter_ready;
  logic       tx_busy;
  logic       tx_timeout;
  logic       tx_overrun;
  logic       interboard_en;
  logic [2:0] interboard_msg_type;
  logic [4:0] interboard_number;
  logic       interboard_rst;

  interboard_link_if lk();

  interboard_link #(
    .TIMEOUT(8),
    .RST_STRETCH(16)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .transmit            (transmit),
    .ctrl_en             (ctrl_en),
    .ctrl_msg_type       (ctrl_msg_type),
    .ctrl_number         (ctrl_number),
    .inter_ready         (inter_ready),
    .tx_busy             (tx_busy),
    .tx_timeout          (tx_timeout),
    .tx_overrun          (tx_overrun),
    .interboard_en       (interboard_en),
    .interboard_msg_type (interboard_msg_type),
    .interboard_number   (interboard_number),
    .interboard_rst      (interboard_rst),
    .link                (lk)
  );

  int passed = 0;
  int total  = 0;
  int n_ir   = 0;
  int n_to   = 0;
  int n_en   = 0;
  int n_irst = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (inter_ready === 1'b1)    n_ir   <= n_ir + 1;
    if (tx_timeout === 1'b1)     n_to   <= n_to + 1;
    if (interboard_en === 1'b1)  n_en   <= n_en + 1;
    if (interboard_rst === 1'b1) n_irst <= n_irst + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if ({inter_ready, tx_busy, tx_timeout, tx_overrun} !== 4'b0)
      $display("FAIL rst_tx_flags: got %b want 0000",
               {inter_ready, tx_busy, tx_timeout, tx_overrun});
    else passed++;
    total++;
    if ({lk.tx_req, lk.tx_ack, lk.tx_data} !== 10'h0)
      $display("FAIL rst_pins: got %h want 000",
               {lk.tx_req, lk.tx_ack, lk.tx_data});
    else passed++;
    total++;
    if ({interboard_en, interboard_msg_type,
         interboard_number, interboard_rst} !== 10'h0)
      $display("FAIL rst_rx: got %h want 000",
               {interboard_en, interboard_msg_type,
                interboard_number, interboard_rst});
    else passed++;
    total++;
    if (lk.rst_remote_out !== 1'b1)
      $display("FAIL rst_remote_out: got %b want 1", lk.rst_remote_out);
    else passed++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_tx_basic();
    int ir0, to0, k;
    ir0 = n_ir;
    to0 = n_to;
    transmit = 1'b1;
    ctrl_en = 1'b1;
    ctrl_msg_type = 3'd2;
    ctrl_number = 5'd17;
    step();
    ctrl_en = 1'b0;
    total++;
    if (lk.tx_req !== 1'b1 || lk.tx_data !== 8'h51)
      $display("FAIL t1_req_data: got %b/%h want 1/51",
               lk.tx_req, lk.tx_data);
    else passed++;
    total++;
    if (tx_busy !== 1'b1)
      $display("FAIL t1_busy: got %b want 1", tx_busy);
    else passed++;
    repeat (4) step();
    lk.rx_ack = 1'b1;
    k = 0;
    while (lk.tx_req === 1'b1 && k < 20) begin
      step();
      k++;
    end
    total++;
    if (lk.tx_req !== 1'b0 || k != 3)
      $display("FAIL t1_req_fall: got req=%b after %0d want 0 after 3",
               lk.tx_req, k);
    else passed++;
    lk.rx_ack = 1'b0;
    step();
    step();
    total++;
    if (inter_ready !== 1'b0)
      $display("FAIL t1_ir_early: got %b want 0", inter_ready);
    else passed++;
    step();
    total++;
    if (inter_ready !== 1'b1 || tx_busy !== 1'b0)
      $display("FAIL t1_ir: got ir=%b busy=%b want 1/0",
               inter_ready, tx_busy);
    else passed++;
    step();
    total++;
    if (inter_ready !== 1'b0 || n_ir - ir0 != 1 || n_to != to0)
      $display("FAIL t1_ir_once: got ir=%b n=%0d to=%0d want 0/1/0",
               inter_ready, n_ir - ir0, n_to - to0);
    else passed++;
  endtask

  task automatic test_rx_basic();
    int en0;
    en0 = n_en;
    lk.rx_data = 8'hA5;
    lk.rx_req = 1'b1;
    step();
    step();
    total++;
    if (interboard_en !== 1'b0)
      $display("FAIL t2_en_early: got %b want 0", interboard_en);
    else passed++;
    step();
    total++;
    if (interboard_en !== 1'b1 || lk.tx_ack !== 1'b1 ||
        interboard_msg_type !== 3'd5 || interboard_number !== 5'd5)
      $display("FAIL t2_capture: got en=%b ack=%b m=%0d n=%0d want 1/1/5/5",
               interboard_en, lk.tx_ack,
               interboard_msg_type, interboard_number);
    else passed++;
    step();
    total++;
    if (interboard_en !== 1'b0)
      $display("FAIL t2_en_pulse: got %b want 0", interboard_en);
    else passed++;
    lk.rx_req = 1'b0;
    lk.rx_data = 8'h00;
    step();
    step();
    total++;
    if (lk.tx_ack !== 1'b1)
      $display("FAIL t2_ack_hold: got %b want 1", lk.tx_ack);
    else passed++;
    step();
    total++;
    if (lk.tx_ack !== 1'b0 || interboard_msg_type !== 3'd5 ||
        interboard_number !== 5'd5 || n_en - en0 != 1)
      $display("FAIL t2_release: got ack=%b m=%0d n=%0d en=%0d want 0/5/5/1",
               lk.tx_ack, interboard_msg_type,
               interboard_number, n_en - en0);
    else passed++;
  endtask

  task automatic test_timeout();
    int ir0, k;
    logic bad;
    ir0 = n_ir;
    bad = 1'b0;
    ctrl_en = 1'b1;
    ctrl_msg_type = 3'd1;
    ctrl_number = 5'd3;
    step();
    ctrl_en = 1'b0;
    for (int i = 1; i < 8; i++) begin
      step();
      if (tx_timeout !== 1'b0 || lk.tx_req !== 1'b1) bad = 1'b1;
    end
    total++;
    if (bad !== 1'b0)
      $display("FAIL t3_early: got early timeout/req drop=%b want 0", bad);
    else passed++;
    step();
    total++;
    if (tx_timeout !== 1'b1 || lk.tx_req !== 1'b0 || tx_busy !== 1'b0)
      $display("FAIL t3_timeout: got to=%b req=%b busy=%b want 1/0/0",
               tx_timeout, lk.tx_req, tx_busy);
    else passed++;
    step();
    total++;
    if (tx_timeout !== 1'b0 || n_ir != ir0)
      $display("FAIL t3_after: got to=%b ir=%0d want 0/0",
               tx_timeout, n_ir - ir0);
    else passed++;
    ctrl_en = 1'b1;
    ctrl_msg_type = 3'd3;
    ctrl_number = 5'd7;
    step();
    ctrl_en = 1'b0;
    lk.rx_ack = 1'b1;
    total++;
    if (lk.tx_data !== 8'h67)
      $display("FAIL t3_resend_data: got %h want 67", lk.tx_data);
    else passed++;
    k = 0;
    while (lk.tx_req === 1'b1 && k < 20) begin
      step();
      k++;
    end
    lk.rx_ack = 1'b0;
    k = 0;
    while (inter_ready !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    total++;
    if (inter_ready !== 1'b1 || tx_timeout !== 1'b0)
      $display("FAIL t3_resend: got ir=%b to=%b want 1/0",
               inter_ready, tx_timeout);
    else passed++;
    step();
  endtask

  task automatic test_overrun();
    int ir0, k;
    ir0 = n_ir;
    total++;
    if (tx_overrun !== 1'b0)
      $display("FAIL t4_ovr_pre: got %b want 0", tx_overrun);
    else passed++;
    ctrl_en = 1'b1;
    ctrl_msg_type = 3'd4;
    ctrl_number = 5'd9;
    step();
    ctrl_msg_type = 3'd7;
    ctrl_number = 5'd31;
    step();
    ctrl_en = 1'b0;
    lk.rx_ack = 1'b1;
    total++;
    if (tx_overrun !== 1'b1 || lk.tx_data !== 8'h89)
      $display("FAIL t4_ovr: got ovr=%b data=%h want 1/89",
               tx_overrun, lk.tx_data);
    else passed++;
    k = 0;
    while (lk.tx_req === 1'b1 && k < 20) begin
      step();
      k++;
    end
    lk.rx_ack = 1'b0;
    repeat (6) step();
    total++;
    if (n_ir - ir0 != 1 || tx_overrun !== 1'b1 ||
        lk.tx_data !== 8'h89 || tx_busy !== 1'b0)
      $display("FAIL t4_done: got ir=%0d ovr=%b data=%h busy=%b want 1/1/89/0",
               n_ir - ir0, tx_overrun, lk.tx_data, tx_busy);
    else passed++;
    transmit = 1'b0;
    ctrl_en = 1'b1;
    step();
    ctrl_en = 1'b0;
    step();
    total++;
    if (lk.tx_req !== 1'b0 || tx_busy !== 1'b0)
      $display("FAIL t4_no_transmit: got req=%b busy=%b want 0/0",
               lk.tx_req, tx_busy);
    else passed++;
    transmit = 1'b1;
  endtask

  task automatic test_duplex();
    int ir0, en0;
    ir0 = n_ir;
    en0 = n_en;
    ctrl_en = 1'b1;
    ctrl_msg_type = 3'd6;
    ctrl_number = 5'd10;
    lk.rx_data = 8'h3C;
    lk.rx_req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      ctrl_en = 1'b0;
      lk.rx_ack = lk.tx_req;
      if (lk.tx_ack === 1'b1) lk.rx_req = 1'b0;
    end
    total++;
    if (n_ir - ir0 != 1 || n_en - en0 != 1)
      $display("FAIL t5_counts: got ir=%0d en=%0d want 1/1",
               n_ir - ir0, n_en - en0);
    else passed++;
    total++;
    if (interboard_msg_type !== 3'd1 || interboard_number !== 5'd28 ||
        lk.tx_data !== 8'hCA)
      $display("FAIL t5_data: got m=%0d n=%0d tx=%h want 1/28/ca",
               interboard_msg_type, interboard_number, lk.tx_data);
    else passed++;
    total++;
    if (tx_busy !== 1'b0 || lk.tx_ack !== 1'b0 || lk.tx_req !== 1'b0)
      $display("FAIL t5_idle: got busy=%b ack=%b req=%b want 0/0/0",
               tx_busy, lk.tx_ack, lk.tx_req);
    else passed++;
  endtask

  task automatic test_reset_remote();
    int en0, irst0, k;
    en0 = n_en;
    ctrl_en = 1'b1;
    ctrl_msg_type = 3'd5;
    ctrl_number = 5'd1;
    step();
    ctrl_en = 1'b0;
    total++;
    if (lk.tx_req !== 1'b1 || tx_busy !== 1'b1)
      $display("FAIL t6_start: got req=%b busy=%b want 1/1",
               lk.tx_req, tx_busy);
    else passed++;
    rst = 1'b1;
    lk.rx_data = 8'h11;
    lk.rx_req = 1'b1;
    step();
    total++;
    if (lk.tx_req !== 1'b0 || tx_busy !== 1'b0 ||
        lk.tx_ack !== 1'b0 || tx_overrun !== 1'b0 ||
        lk.rst_remote_out !== 1'b1)
      $display("FAIL t6_rst: got req=%b busy=%b ack=%b ovr=%b ro=%b want 0/0/0/0/1",
               lk.tx_req, tx_busy, lk.tx_ack, tx_overrun,
               lk.rst_remote_out);
    else passed++;
    step();
    step();
    lk.rx_req = 1'b0;
    step();
    rst = 1'b0;
    k = 0;
    while (lk.rst_remote_out === 1'b1 && k < 40) begin
      k++;
      step();
    end
    total++;
    if (k != 16)
      $display("FAIL t6_stretch: got %0d cycles want 16", k);
    else passed++;
    step();
    total++;
    if (n_en != en0 || lk.tx_ack !== 1'b0)
      $display("FAIL t6_discard: got en=%0d ack=%b want 0/0",
               n_en - en0, lk.tx_ack);
    else passed++;
    irst0 = n_irst;
    lk.rst_remote_in = 1'b1;
    step();
    step();
    total++;
    if (interboard_rst !== 1'b0)
      $display("FAIL t6_irst_early: got %b want 0", interboard_rst);
    else passed++;
    step();
    total++;
    if (interboard_rst !== 1'b1)
      $display("FAIL t6_irst: got %b want 1", interboard_rst);
    else passed++;
    repeat (10) step();
    total++;
    if (n_irst - irst0 != 1 || interboard_rst !== 1'b0)
      $display("FAIL t6_irst_once: got n=%0d now=%b want 1/0",
               n_irst - irst0, interboard_rst);
    else passed++;
    lk.rst_remote_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    transmit = 1'b0;
    ctrl_en = 1'b0;
    ctrl_msg_type = 3'd0;
    ctrl_number = 5'd0;
    lk.rx_ack = 1'b0;
    lk.rx_req = 1'b0;
    lk.rx_data = 8'h00;
    lk.rst_remote_in = 1'b0;
    test_reset();
    test_tx_basic();
    test_rx_basic();
    test_timeout();
    test_overrun();
    test_duplex();
    test_reset_remote();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
